// File: rtl/div_pkg.sv
// Shared constants and sample type for the divide-by-4 datapath and its output buffer.
package div_pkg;

   localparam int unsigned DIV_WIDTH  = 4;
   localparam int unsigned DIVQ_DEPTH = 4;

   typedef logic [DIV_WIDTH-1:0] div_sample_t;

endpackage : div_pkg

// File: rtl/divq_mem.sv
// DEPTH x WIDTH register array for divq_buffer: one synchronous write port,
// one asynchronous read port, whole array cleared on reset.
module divq_mem #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : divq_mem

// File: rtl/divq_buffer.sv
// Show-ahead FIFO behind the divide-by-4 block with a sticky overflow flag.
// Optional zero-latency fall-through when empty: define DIVQ_BYPASS_EN.
module divq_buffer
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned DEPTH = DIVQ_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       valid_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       overflow_o,
   input  logic                       clr_i
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             overflow;
   logic [WIDTH-1:0] mem_rdata;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             drop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

`ifdef DIVQ_BYPASS_EN
   // pop only ever refers to a stored entry; a fall-through sample that is
   // taken in its arrival cycle never touches the memory.
   logic bypass;
   assign bypass  = empty && valid_i;
   assign data_o  = bypass ? data_i : mem_rdata;
   assign valid_o = !empty || valid_i;
   assign pop     = !empty && ready_i;
   assign push    = valid_i && !(bypass && ready_i) && (!full || pop);
`else
   assign data_o  = mem_rdata;
   assign valid_o = !empty;
   assign pop     = valid_o && ready_i;
   assign push    = valid_i && (!full || pop);
`endif

   assign drop       = valid_i && full && !pop;
   assign count_o    = count;
   assign overflow_o = overflow;

   divq_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (data_i),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A new drop takes priority over a clear in the same cycle.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_i) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule : divq_buffer

// File: tb/tb_divq_buffer.sv
// Self-checking bench for divq_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_divq_buffer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef DIVQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] data_i;
   logic             valid_i;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             ready_i;
   logic [CW-1:0]    count_o;
   logic             overflow_o;
   logic             clr_i;

   divq_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .count_o    (count_o),
      .overflow_o (overflow_o),
      .clr_i      (clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned      errors = 0;
   int unsigned      checks = 0;
   logic [WIDTH-1:0] q[$];
   bit               ovf_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare outputs with the model's view of the queue and current inputs.
   task automatic check_outputs(input string tag);
      bit               exp_valid;
      logic [WIDTH-1:0] exp_data;
      exp_valid = (q.size() != 0) || (BYP && valid_i);
      chk({tag, ".valid"}, 32'(valid_o), 32'(exp_valid));
      if (exp_valid) begin
         exp_data = (q.size() != 0) ? q[0] : data_i;
         chk({tag, ".data"}, 32'(data_o), 32'(exp_data));
      end
      chk({tag, ".count"}, 32'(count_o), q.size());
      chk({tag, ".ovf"}, 32'(overflow_o), 32'(ovf_m));
   endtask

   // Drive one cycle of inputs, check outputs, advance the model across the edge.
   task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r,
                       input bit c, input string tag);
      bit taken, pop_q, push_q, drop_q;
      valid_i = v;
      data_i  = d;
      ready_i = r;
      clr_i   = c;
      #1;
      check_outputs(tag);
      taken  = BYP && (q.size() == 0) && v && r;
      pop_q  = (q.size() != 0) && r;
      push_q = v && !taken && ((q.size() < DEPTH) || pop_q);
      drop_q = v && (q.size() == DEPTH) && !pop_q;
      if (pop_q) void'(q.pop_front());
      if (push_q) q.push_back(d);
      if (drop_q) ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) begin
         step(1'b0, '0, 1'b1, 1'b0, tag);
      end
      step(1'b0, '0, 1'b0, 1'b0, {tag, ".empty"});
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0; clr_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rst.count", 32'(count_o), 0);
      chk("rst.valid", 32'(valid_o), 0);
      chk("rst.data", 32'(data_o), 0);
      chk("rst.ovf", 32'(overflow_o), 0);
      rst = 1'b0;

      // Asynchronous reset while holding two entries.
      step(1'b1, 4'h1, 1'b0, 1'b0, "mid.push");
      step(1'b1, 4'h2, 1'b0, 1'b0, "mid.push");
      valid_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid.rst.count", 32'(count_o), 0);
      chk("mid.rst.valid", 32'(valid_o), 0);
      chk("mid.rst.data", 32'(data_o), 0);
      chk("mid.rst.ovf", 32'(overflow_o), 0);
      rst = 1'b0;
      q.delete();
      ovf_m = 1'b0;
      @(posedge clk);
      #1;

      // Ordering
      for (int i = 1; i <= 3; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, "ord.push");
      drain("ord.pop");

      // Overflow: fifth sample is dropped
      for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, "ovf.push");
      step(1'b0, '0, 1'b0, 1'b0, "ovf.hold");
      chk("ovf.full", 32'(count_o), DEPTH);
      drain("ovf.pop");

      // Full with simultaneous push and pop
      step(1'b0, '0, 1'b0, 1'b1, "fpp.clr");
      for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, "fpp.fill");
      step(1'b1, 4'hA, 1'b1, 1'b0, "fpp.both");
      chk("fpp.count", 32'(count_o), DEPTH);
      chk("fpp.ovf", 32'(overflow_o), 0);
      drain("fpp.pop");

      // Pointer wrap with ready toggling
      for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(i), (i % 2) == 0, 1'b0, "wrap");
      drain("wrap.pop");

      // Clear alone, then clear together with a drop
      for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i + 8), 1'b0, 1'b0, "cvs.fill");
      step(1'b0, '0, 1'b0, 1'b1, "cvs.clr");
      chk("cvs.cleared", 32'(overflow_o), 0);
      step(1'b1, 4'hF, 1'b0, 1'b1, "cvs.clrdrop");
      chk("cvs.set_wins", 32'(overflow_o), 1);
      drain("cvs.pop");
      step(1'b0, '0, 1'b0, 1'b1, "cvs.clr2");

`ifdef DIVQ_BYPASS_EN
      valid_i = 1'b1; data_i = 4'h7; ready_i = 1'b1; clr_i = 1'b0;
      #1;
      chk("byp.data", 32'(data_o), 32'h7);
      chk("byp.valid", 32'(valid_o), 1);
      @(posedge clk);
      #1;
      valid_i = 1'b0; ready_i = 1'b0;
      #1;
      chk("byp.count", 32'(count_o), 0);
      @(posedge clk);
      #1;
`endif

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, WIDTH'($urandom_range(0, 15)),
              $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, "rnd");
      end
      drain("rnd.pop");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_divq_buffer
